// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 pipeline: fetch FSM states and common constants.
package rv32_pkg;

  typedef enum logic {
    FETCH_RUN,
    FETCH_DRAIN
  } rv32_fetch_state_t;

  localparam logic [31:0] RV32_NOP                  = 32'h0000_0013;
  localparam logic [31:0] RV32_RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Word-aligns a byte address by forcing the two low bits to zero.
  function automatic logic [31:0] rv32_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_fetch_hold.sv
// One-entry {pc, instr} holding register. It catches an instruction that returns
// from the bus while the fetch stage is stalled. clear wins over load.
module rv32_fetch_hold
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Occupancy flag: only this bit needs a defined value after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload capture.
  // NOTE: the payload is deliberately left unreset; it is never consumed while
  // valid is low, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/rv32_fetch.sv
// Instruction fetch stage. Owns the PC, runs a valid/ready read on the
// instruction bus and presents {pc, instr, valid} to the fetch/decode register.
// Honours stall/flush from the hazard unit and branch redirects from mem.
module rv32_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RV32_RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_pc_in,
  output logic [31:0] instr_address_out,
  output logic        instr_read_out,
  input  logic        instr_ready_in,
  input  logic [31:0] instr_read_value_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  rv32_fetch_state_t state, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] pc_out_d, instr_out_d;
  logic        valid_out_d;

  logic        hold_valid_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic        hold_load, hold_clear;

  logic        handshake;
  logic [31:0] branch_target;
  logic [31:0] pc_plus4;

  // The low bits of the redirect target are discarded by word alignment.
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^branch_pc_in[1:0];

  // Bus request: always reading unless a stalled instruction is parked in hold.
  // A pending request cannot be withdrawn because pc_q and state only move on
  // a handshake or a redirect that goes through DRAIN.
  assign instr_address_out = pc_q;
  assign instr_read_out    = (state == FETCH_DRAIN) || !hold_valid_q;
  assign handshake         = instr_read_out && instr_ready_in;
  assign branch_target     = rv32_word_align(branch_pc_in);
  assign pc_plus4          = pc_q + 32'd4;  // wraps silently at the top of memory

  rv32_fetch_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_pc    (pc_q),
    .load_instr (instr_read_value_in),
    .valid      (hold_valid_q),
    .pc         (hold_pc_q),
    .instr      (hold_instr_q)
  );

  // Next-state decision for PC, FSM, redirect target, outputs and hold buffer.
  always_comb begin
    // NOTE: every signal gets a default before the decision tree so that no
    // path leaves one unassigned, which would infer a latch.
    state_d       = state;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    pc_out_d      = pc_out;
    instr_out_d   = instr_out;
    valid_out_d   = valid_out;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;

    case (state)
      FETCH_RUN: begin
        if (branch_taken_in) begin
          // Redirect beats stall and flush; anything in flight or parked is dropped.
          valid_out_d = 1'b0;
          hold_clear  = 1'b1;
          if (instr_read_out && !instr_ready_in) begin
            redirect_pc_d = branch_target;
            state_d       = FETCH_DRAIN;
          end else begin
            pc_d = branch_target;
          end
        end else if (handshake && !stall_in) begin
          // A handshake in RUN implies the hold buffer is empty.
          pc_out_d    = pc_q;
          instr_out_d = instr_read_value_in;
          valid_out_d = !flush_in;
          pc_d        = pc_plus4;
        end else if (handshake) begin
          // Data arrived during a stall: park it and keep the outputs.
          hold_load = 1'b1;
          pc_d      = pc_plus4;
        end else if (hold_valid_q && !stall_in) begin
          pc_out_d    = hold_pc_q;
          instr_out_d = hold_instr_q;
          valid_out_d = !flush_in;
          hold_clear  = 1'b1;
        end else if (!stall_in) begin
          valid_out_d = 1'b0;
        end
      end

      FETCH_DRAIN: begin
        // Retire the orphaned access at the old address, then jump.
        valid_out_d = 1'b0;
        if (branch_taken_in) begin
          redirect_pc_d = branch_target;
        end
        if (handshake) begin
          pc_d    = branch_taken_in ? branch_target : redirect_pc_q;
          state_d = FETCH_RUN;
        end
      end
    endcase
  end

  // State, PC and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state         <= FETCH_RUN;
      pc_q          <= RESET_VECTOR;
      redirect_pc_q <= RESET_VECTOR;
      pc_out        <= 32'h0000_0000;
      instr_out     <= RV32_NOP;
      valid_out     <= 1'b0;
    end else begin
      state         <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      pc_out        <= pc_out_d;
      instr_out     <= instr_out_d;
      valid_out     <= valid_out_d;
    end
  end

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed bench for rv32_fetch with RESET_VECTOR = 0x100. The bus model returns
// word(addr) unless a specific value is forced for one step.
module tb_rv32_fetch;
  import rv32_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        flush_in;
  logic        branch_taken_in;
  logic [31:0] branch_pc_in;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic        instr_ready_in;
  logic [31:0] instr_read_value_in;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  int          n_vectors;
  int          n_miscompares;
  logic        force_en;
  logic [31:0] force_val;

  rv32_fetch #(.RESET_VECTOR(RV)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_in            (stall_in),
    .flush_in            (flush_in),
    .branch_taken_in     (branch_taken_in),
    .branch_pc_in        (branch_pc_in),
    .instr_address_out   (instr_address_out),
    .instr_read_out      (instr_read_out),
    .instr_ready_in      (instr_ready_in),
    .instr_read_value_in (instr_read_value_in),
    .pc_out              (pc_out),
    .instr_out           (instr_out),
    .valid_out           (valid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present bus data for the current address, then advance one clock and
  // settle 1 time unit past the edge.
  task automatic step();
    instr_read_value_in = force_en ? force_val : word(instr_address_out);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_vectors = 0; n_miscompares = 0;
    force_en = 1'b0; force_val = '0;
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    branch_taken_in = 1'b0; branch_pc_in = '0;
    instr_ready_in = 1'b1; instr_read_value_in = '0;

    // Reset values
    @(posedge clk); #1;
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr", instr_out, 32'h0000_0013);
    check("rst_addr", instr_address_out, RV);
    reset = 1'b0;

    // Zero-wait streaming: outputs lag address by one cycle
    for (int i = 0; i < 4; i++) begin
      check("z_addr", instr_address_out, RV + 32'(4 * i));
      check("z_read", {31'b0, instr_read_out}, 32'd1);
      step();
      check("z_pc", pc_out, RV + 32'(4 * i));
      check("z_instr", instr_out, word(RV + 32'(4 * i)));
      check("z_valid", {31'b0, valid_out}, 32'd1);
    end

    // Wait states at 0x104
    pulse_reset();
    step();
    check("w_pc0", pc_out, 32'h100);
    instr_ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("w_addr", instr_address_out, 32'h104);
      check("w_read", {31'b0, instr_read_out}, 32'd1);
      check("w_valid", {31'b0, valid_out}, 32'd0);
    end
    instr_ready_in = 1'b1;
    step();
    check("w_pc", pc_out, 32'h104);
    check("w_instr", instr_out, word(32'h104));
    check("w_valid1", {31'b0, valid_out}, 32'd1);

    // Stall while 0xDEADBEEF returns at 0x108
    check("s_addr", instr_address_out, 32'h108);
    stall_in = 1'b1; force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    step();
    force_en = 1'b0;
    check("s_read_drop", {31'b0, instr_read_out}, 32'd0);
    check("s_pc_held", pc_out, 32'h104);
    check("s_valid_held", {31'b0, valid_out}, 32'd1);
    step();
    check("s_pc_held2", pc_out, 32'h104);
    check("s_instr_held2", instr_out, word(32'h104));
    stall_in = 1'b0;
    step();
    check("s_pc", pc_out, 32'h108);
    check("s_instr", instr_out, 32'hDEAD_BEEF);
    check("s_valid", {31'b0, valid_out}, 32'd1);
    check("s_read_resume", {31'b0, instr_read_out}, 32'd1);
    check("s_addr_next", instr_address_out, 32'h10C);

    // Branch to 0x203 while a read is pending -> DRAIN
    instr_ready_in = 1'b0; branch_taken_in = 1'b1; branch_pc_in = 32'h203;
    step();
    branch_taken_in = 1'b0;
    check("d_state", {31'b0, dut.state}, 32'(FETCH_DRAIN));
    check("d_addr_held", instr_address_out, 32'h10C);
    check("d_valid", {31'b0, valid_out}, 32'd0);
    step();
    check("d_addr_held2", instr_address_out, 32'h10C);
    instr_ready_in = 1'b1;
    step();
    check("d_state_run", {31'b0, dut.state}, 32'(FETCH_RUN));
    check("d_addr_target", instr_address_out, 32'h200);
    check("d_discard", {31'b0, valid_out}, 32'd0);
    step();
    check("d_pc", pc_out, 32'h200);
    check("d_instr", instr_out, word(32'h200));
    check("d_valid1", {31'b0, valid_out}, 32'd1);

    // Branch together with stall while hold is full
    stall_in = 1'b1;
    step();
    check("bh_read_drop", {31'b0, instr_read_out}, 32'd0);
    branch_taken_in = 1'b1; branch_pc_in = 32'h300;
    step();
    branch_taken_in = 1'b0; stall_in = 1'b0;
    check("bh_addr", instr_address_out, 32'h300);
    check("bh_read", {31'b0, instr_read_out}, 32'd1);
    check("bh_valid", {31'b0, valid_out}, 32'd0);
    step();
    check("bh_pc", pc_out, 32'h300);
    check("bh_valid1", {31'b0, valid_out}, 32'd1);

    // Reset asserted mid-DRAIN acts immediately
    instr_ready_in = 1'b0; branch_taken_in = 1'b1; branch_pc_in = 32'h400;
    step();
    branch_taken_in = 1'b0;
    check("rd_state_drain", {31'b0, dut.state}, 32'(FETCH_DRAIN));
    #2;
    reset = 1'b1;
    #1;
    check("rd_state", {31'b0, dut.state}, 32'(FETCH_RUN));
    check("rd_pc_q", dut.pc_q, RV);
    check("rd_addr", instr_address_out, RV);
    check("rd_valid", {31'b0, valid_out}, 32'd0);
    check("rd_instr", instr_out, 32'h0000_0013);
    check("rd_pc_out", pc_out, 32'h0);
    reset = 1'b0;
    instr_ready_in = 1'b1;

    // Flush bubbles the output but the PC still advances
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check("f_valid", {31'b0, valid_out}, 32'd0);
    check("f_addr", instr_address_out, 32'h104);

    // PC wrap at the top of the address space; low target bits ignored
    branch_taken_in = 1'b1; branch_pc_in = 32'hFFFF_FFFF;
    step();
    branch_taken_in = 1'b0;
    check("wr_addr", instr_address_out, 32'hFFFF_FFFC);
    check("wr_valid", {31'b0, valid_out}, 32'd0);
    step();
    check("wr_pc", pc_out, 32'hFFFF_FFFC);
    check("wr_instr", instr_out, word(32'hFFFF_FFFC));
    check("wr_addr_wrap", instr_address_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
